// File: rtl/dot_prod_lanes.sv
// dot_prod_lanes: banked multi-lane dot-product / squared-distance engine with host array access
module dot_prod_lanes #(
  parameter int DW    = 27,
  parameter int AW    = 10,
  parameter int DEPTH = 1000,
  parameter int LANES = 4,
  parameter int ACCW  = 64,
  parameter int SAT   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r_enable,
  input  logic            mode,
  input  logic [AW-1:0]   init_i,
  input  logic [AW-1:0]   init_n,
  input  logic [ACCW-1:0] init_acc,
  input  logic            controlArr,
  input  logic            controlArrWEnable_a,
  input  logic            controlArrWEnable_b,
  input  logic [AW-1:0]   controlArrAddr_a,
  input  logic [AW-1:0]   controlArrAddr_b,
  input  logic [DW-1:0]   controlArrWData_a,
  input  logic [DW-1:0]   controlArrWData_b,
  output logic [DW-1:0]   controlArrRData_a,
  output logic [DW-1:0]   controlArrRData_b,
  output logic            busy,
  output logic            w_enable,
  output logic [ACCW-1:0] result,
  output logic            ovf
);
  localparam int ROWS = (DEPTH + LANES - 1) / LANES;
  localparam int RB   = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int LB   = LANES > 1 ? $clog2(LANES) : 1;
  localparam int EW   = AW + 2;
  localparam int AWP  = AW + 1;
  localparam int PW   = 2 * DW + 2;
  localparam int DW1  = DW + 1;
  localparam int AW1  = ACCW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, busy_q, busy_d, wen_q, wen_d, ovf_q, ovf_d;
  logic drain_q, drain_d, s1_q, s1_d, s2_q, s2_d, grant;
  logic [EW-1:0] base_q, base_d, n_q, n_d, em;
  logic signed [ACCW-1:0] acc_q, acc_d, result_q, result_d, lane_sum;
  logic signed [AW1-1:0] acc_ext;
  logic [RB-1:0] ra_q [LANES];
  logic [RB-1:0] ra_d [LANES];
  logic rv_q [LANES];
  logic rv_d [LANES];
  logic signed [PW-1:0] p_q [LANES];
  logic signed [PW-1:0] p_d [LANES];
  logic signed [DW-1:0] a_v, b_v;
  logic signed [DW1-1:0] dif;
  logic signed [DW-1:0] mem_a [2**LB][2**RB];
  logic signed [DW-1:0] mem_b [2**LB][2**RB];
  logic [LB-1:0] hb_a_q, hb_a_d, hb_b_q, hb_b_d;
  logic [RB-1:0] hr_a_q, hr_a_d, hr_b_q, hr_b_d;
  logic hv_a_q, hv_a_d, hv_b_q, hv_b_d;
  always_comb begin
    grant = controlArr && !busy_q;
    hv_a_d = grant && AWP'(controlArrAddr_a) < AWP'(DEPTH);
    hv_b_d = grant && AWP'(controlArrAddr_b) < AWP'(DEPTH);
    hb_a_d = LB'(controlArrAddr_a % AW'(LANES));
    hb_b_d = LB'(controlArrAddr_b % AW'(LANES));
    hr_a_d = RB'(controlArrAddr_a / AW'(LANES));
    hr_b_d = RB'(controlArrAddr_b / AW'(LANES));
    state_d = state_q;
    mode_d = mode_q;
    base_d = base_q;
    n_d = n_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    drain_d = drain_q;
    result_d = result_q;
    wen_d = 1'b0;
    s1_d = state_q == RUN;
    s2_d = s1_q;
    lane_sum = '0;
    em = '0;
    a_v = '0;
    b_v = '0;
    dif = '0;
    for (int m = 0; m < LANES; m++) begin
      // bank m serves whichever lane of this beat lands on it, so each bank sees one read per beat
      em = base_q + EW'((m + LANES - int'(base_q % EW'(LANES))) % LANES);
      ra_d[m] = RB'(em / EW'(LANES));
      rv_d[m] = state_q == RUN && em < n_q && em < EW'(DEPTH);
      a_v = mem_a[LB'(m)][ra_q[m]];
      b_v = mem_b[LB'(m)][ra_q[m]];
      dif = DW1'(a_v) - DW1'(b_v);
      p_d[m] = !rv_q[m] ? '0 : mode_q ? PW'(dif) * PW'(dif) : PW'(a_v) * PW'(b_v);
      lane_sum = lane_sum + ACCW'(p_q[m]);
    end
    acc_ext = AW1'(acc_q) + AW1'(lane_sum);
    if (s2_q) begin
      acc_d = acc_ext[ACCW-1:0];
      if (acc_ext[ACCW] != acc_ext[ACCW-1]) begin
        ovf_d = 1'b1;
        if (SAT != 0) acc_d = acc_ext[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
      end
    end
    if (state_q == IDLE && r_enable && !controlArr) begin
      mode_d = mode;
      base_d = EW'(init_i);
      n_d = EW'(init_n);
      acc_d = init_acc;
      ovf_d = 1'b0;
      state_d = init_n <= init_i ? DONE : RUN;
    end
    if (state_q == RUN) begin
      base_d = base_q + EW'(LANES);
      drain_d = 1'b0;
      state_d = base_q + EW'(LANES) >= n_q ? DRAIN : RUN;
    end
    if (state_q == DRAIN) begin
      drain_d = 1'b1;
      state_d = drain_q ? DONE : DRAIN;
    end
    if (state_q == DONE) begin
      state_d = IDLE;
      wen_d = 1'b1;
      result_d = acc_q;
    end
    busy_d = state_d != IDLE || wen_d;
  end
  always_ff @(posedge clk) begin
    if (grant && controlArrWEnable_a && hv_a_d) mem_a[hb_a_d][hr_a_d] <= controlArrWData_a;
    if (grant && controlArrWEnable_b && hv_b_d) mem_b[hb_b_d][hr_b_d] <= controlArrWData_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      wen_q <= 1'b0;
      ovf_q <= 1'b0;
      drain_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      base_q <= '0;
      n_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      hb_a_q <= '0;
      hb_b_q <= '0;
      hr_a_q <= '0;
      hr_b_q <= '0;
      hv_a_q <= 1'b0;
      hv_b_q <= 1'b0;
      for (int m = 0; m < LANES; m++) begin
        ra_q[m] <= '0;
        rv_q[m] <= 1'b0;
        p_q[m] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      wen_q <= wen_d;
      ovf_q <= ovf_d;
      drain_q <= drain_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      base_q <= base_d;
      n_q <= n_d;
      acc_q <= acc_d;
      result_q <= result_d;
      hb_a_q <= hb_a_d;
      hb_b_q <= hb_b_d;
      hr_a_q <= hr_a_d;
      hr_b_q <= hr_b_d;
      hv_a_q <= hv_a_d;
      hv_b_q <= hv_b_d;
      for (int m = 0; m < LANES; m++) begin
        ra_q[m] <= ra_d[m];
        rv_q[m] <= rv_d[m];
        p_q[m] <= p_d[m];
      end
    end
  end
  assign controlArrRData_a = hv_a_q && !busy_q ? mem_a[hb_a_q][hr_a_q] : '0;
  assign controlArrRData_b = hv_b_q && !busy_q ? mem_b[hb_b_q][hr_b_q] : '0;
  assign busy = busy_q;
  assign w_enable = wen_q;
  assign result = result_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_dot_prod_lanes.sv
// tb_dot_prod_lanes: scoreboard bench for dot_prod_lanes, wrap and saturate builds side by side
module tb_dot_prod_lanes;
  localparam int DW = 27, AW = 10, DEPTH = 1000, LANES = 4, ACCW = 64;
  localparam logic signed [64:0] MAXV = 65'sh0_7fff_ffff_ffff_ffff;
  localparam logic signed [64:0] MINV = 65'sh1_8000_0000_0000_0000;
  logic clk = 0, rst = 1, r_enable = 0, mode = 0, controlArr = 0, wea = 0, web = 0;
  logic [AW-1:0] init_i = 0, init_n = 0, aa = 0, ab = 0;
  logic [ACCW-1:0] init_acc = 0;
  logic [DW-1:0] wda = 0, wdb = 0, rda0, rdb0, rda1, rdb1;
  logic busy0, busy1, wen0, wen1, ovf0, ovf1;
  logic [ACCW-1:0] res0, res1;
  int cyc = 0, errors = 0, checks = 0, c_lo = -10, c_hi = -10;
  logic rd_issue = 0, rd_v = 0;
  longint ma [DEPTH];
  longint mb [DEPTH];
  typedef struct {logic [ACCW-1:0] res; logic ovf; int cy;} exp_t;
  typedef struct {logic [DW-1:0] a; logic [DW-1:0] b;} rd_t;
  exp_t q0[$], q1[$];
  rd_t rq[$];
  dot_prod_lanes #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LANES(LANES), .ACCW(ACCW), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .mode(mode), .init_i(init_i), .init_n(init_n),
    .init_acc(init_acc), .controlArr(controlArr), .controlArrWEnable_a(wea), .controlArrWEnable_b(web),
    .controlArrAddr_a(aa), .controlArrAddr_b(ab), .controlArrWData_a(wda), .controlArrWData_b(wdb),
    .controlArrRData_a(rda0), .controlArrRData_b(rdb0), .busy(busy0), .w_enable(wen0),
    .result(res0), .ovf(ovf0));
  dot_prod_lanes #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LANES(LANES), .ACCW(ACCW), .SAT(1)) u1 (
    .clk(clk), .rst(rst), .r_enable(r_enable), .mode(mode), .init_i(init_i), .init_n(init_n),
    .init_acc(init_acc), .controlArr(controlArr), .controlArrWEnable_a(wea), .controlArrWEnable_b(web),
    .controlArrAddr_a(aa), .controlArrAddr_b(ab), .controlArrWData_a(wda), .controlArrWData_b(wdb),
    .controlArrRData_a(rda1), .controlArrRData_b(rdb1), .busy(busy1), .w_enable(wen1),
    .result(res1), .ovf(ovf1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_v <= rd_issue;
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  always @(negedge clk) begin
    logic be;
    exp_t e;
    rd_t r;
    if (!rst) begin
      be = cyc > c_lo && cyc <= c_hi;
      chk("busy_wrap", 64'(busy0), 64'(be));
      chk("busy_sat", 64'(busy1), 64'(be));
      if (wen0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_wrap: unexpected w_enable at cycle %0d", cyc);
        end else begin
          e = q0.pop_front();
          chk("result_wrap", res0, e.res);
          chk("ovf_wrap", 64'(ovf0), 64'(e.ovf));
          chk("strobe_cycle_wrap", 64'(cyc), 64'(e.cy));
        end
      end
      if (wen1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_sat: unexpected w_enable at cycle %0d", cyc);
        end else begin
          e = q1.pop_front();
          chk("result_sat", res1, e.res);
          chk("ovf_sat", 64'(ovf1), 64'(e.ovf));
          chk("strobe_cycle_sat", 64'(cyc), 64'(e.cy));
        end
      end
      if (rd_v && rq.size() > 0) begin
        r = rq.pop_front();
        chk("rdata_a_wrap", 64'(rda0), 64'(r.a));
        chk("rdata_b_wrap", 64'(rdb0), 64'(r.b));
        chk("rdata_a_sat", 64'(rda1), 64'(r.a));
        chk("rdata_b_sat", 64'(rdb1), 64'(r.b));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic hwrite(int addr, logic [DW-1:0] va, logic [DW-1:0] vb, bit track);
    controlArr = 1; wea = 1; web = 1;
    aa = AW'(addr); ab = AW'(addr); wda = va; wdb = vb;
    if (track) begin
      ma[addr] = longint'($signed(va));
      mb[addr] = longint'($signed(vb));
    end
    tick();
    wea = 0; web = 0; controlArr = 0;
  endtask
  task automatic hread(int addr, logic [DW-1:0] ea, logic [DW-1:0] eb);
    controlArr = 1; aa = AW'(addr); ab = AW'(addr); rd_issue = 1;
    rq.push_back('{ea, eb});
    tick();
    rd_issue = 0; controlArr = 0;
  endtask
  function automatic void model(bit m, int i, int n, logic [63:0] acc, bit sat,
                                output logic [63:0] res, output logic o);
    logic signed [64:0] t;
    longint s, d;
    o = 0;
    res = acc;
    for (int e0 = i; e0 < n; e0 += LANES) begin
      s = 0;
      for (int j = 0; j < LANES; j++)
        if (e0 + j < n && e0 + j < DEPTH) begin
          d = ma[e0+j] - mb[e0+j];
          s += m ? d * d : ma[e0+j] * mb[e0+j];
        end
      t = 65'($signed(res)) + 65'(s);
      if (t > MAXV || t < MINV) begin
        o = 1;
        res = sat ? (t < 0 ? 64'h8000_0000_0000_0000 : 64'h7fff_ffff_ffff_ffff) : t[63:0];
      end else res = t[63:0];
    end
  endfunction
  task automatic start(bit m, int i, int n, logic [63:0] acc, logic [63:0] r0, logic o0,
                       logic [63:0] r1, logic o1, bit push);
    int cs;
    mode = m; init_i = AW'(i); init_n = AW'(n); init_acc = acc; r_enable = 1;
    cs = cyc + (n > i ? (n - i + LANES - 1) / LANES + 4 : 2);
    if (push) begin
      q0.push_back('{r0, o0, cs});
      q1.push_back('{r1, o1, cs});
    end
    c_lo = cyc;
    c_hi = cs;
    tick();
    r_enable = 0; mode = ~m; init_i = AW'($urandom); init_n = AW'($urandom);
    init_acc = {$urandom, $urandom};
  endtask
  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      if (!busy0 && !busy1) break;
      tick();
    end
    checks++;
    if (k == 300) begin
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles", k);
    end
    tick();
  endtask
  task automatic run(bit m, int i, int n, logic [63:0] acc, logic [63:0] r0, logic o0,
                     logic [63:0] r1, logic o1);
    start(m, i, n, acc, r0, o0, r1, o1, 1);
    wait_idle();
  endtask
  task automatic run_model(bit m, int i, int n, logic [63:0] acc);
    logic [63:0] r0, r1;
    logic o0, o1;
    model(m, i, n, acc, 0, r0, o0);
    model(m, i, n, acc, 1, r1, o1);
    run(m, i, n, acc, r0, o0, r1, o1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] r0, r1, acc;
    logic o0, o1;
    int i, n, sel;
    repeat (3) tick();
    rst = 0;
    chk("reset_result_wrap", res0, 0);
    chk("reset_result_sat", res1, 0);
    chk("reset_ovf", 64'({ovf0, ovf1}), 0);
    chk("reset_wen", 64'({wen0, wen1}), 0);
    for (int k = 0; k < DEPTH; k++) hwrite(k, DW'($urandom), DW'($urandom), 1);
    for (int k = 0; k < 8; k++) begin
      i = (k == 0) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
      hread(i, DW'(ma[i]), DW'(mb[i]));
    end
    for (int k = 0; k < 24; k++) begin
      i = int'($urandom_range(0, 1015));
      n = i + int'($urandom_range(0, 44)) - 3;
      if (k == 0) begin i = 995; n = 1010; end
      if (k == 1) begin i = 1000; n = 1020; end
      if (n > 1023) n = 1023;
      if (n < 0) n = 0;
      sel = int'($urandom_range(0, 2));
      acc = sel == 0 ? {$urandom, $urandom} :
            sel == 1 ? 64'h7fc0_0000_0000_0000 | 64'($urandom) : 64'h8030_0000_0000_0000 | 64'($urandom);
      run_model(1'($urandom), i, n, acc);
    end
    for (int k = 0; k < 10; k++) hwrite(k, DW'(k), DW'(1), 1);
    run(0, 0, 10, 64'd5, 64'd50, 0, 64'd50, 0);
    for (int k = 0; k < 10; k++) hwrite(k, DW'(k), DW'(2), 1);
    run(0, 3, 8, 64'd0, 64'd50, 0, 64'd50, 0);
    hwrite(0, DW'(10), DW'(4), 1);
    hwrite(1, DW'(3), DW'(7), 1);
    run(1, 0, 2, 64'd0, 64'd52, 0, 64'd52, 0);
    hwrite(0, DW'(-5), DW'(3), 1);
    run(1, 0, 1, 64'd0, 64'd64, 0, 64'd64, 0);
    start(0, 5, 5, -64'sd7, -64'sd7, 0, -64'sd7, 0, 1);
    r_enable = 1;
    tick();
    r_enable = 0;
    wait_idle();
    controlArr = 1; r_enable = 1;
    tick();
    controlArr = 0; r_enable = 0;
    repeat (8) tick();
    for (int k = 0; k < 4; k++) hwrite(k, DW'(4), DW'(4), 1);
    run(0, 0, 4, 64'h7fff_ffff_ffff_fff5, 64'h8000_0000_0000_0035, 1, 64'h7fff_ffff_ffff_ffff, 1);
    start(0, 0, 40, 64'd123, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1;
    c_hi = cyc;
    tick();
    rst = 0;
    chk("midrun_reset_result_wrap", res0, 0);
    chk("midrun_reset_result_sat", res1, 0);
    chk("midrun_reset_ovf", 64'({ovf0, ovf1}), 0);
    repeat (40) tick();
    hwrite(0, DW'(111), DW'(222), 1);
    model(1, 0, 40, 64'd0, 0, r0, o0);
    model(1, 0, 40, 64'd0, 1, r1, o1);
    start(1, 0, 40, 64'd0, r0, o0, r1, o1, 1);
    tick();
    hwrite(0, DW'(333), DW'(444), 0);
    hread(0, DW'(0), DW'(0));
    r_enable = 1;
    tick();
    r_enable = 0;
    wait_idle();
    hread(0, DW'(111), DW'(222));
    repeat (5) tick();
    chk("queues_drained", 64'(q0.size() + q1.size() + rq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_prod_lanes.md
DOT_PROD_LANES -- requirements
Module: dot_prod_lanes

Interface
REQ-001 SHALL have parameter DW, default 27, signed element width.
REQ-002 SHALL have parameter AW, default 10, element address width.
REQ-003 SHALL have parameter DEPTH, default 1000, elements per array (DEPTH <= 2^AW).
REQ-004 SHALL have parameter LANES, default 4, elements processed per beat (power of 2, 1..8).
REQ-005 SHALL have parameter ACCW, default 64, accumulator width (ACCW >= 2*DW+2).
REQ-006 SHALL have parameter SAT, default 0, where 0 means wrap on overflow and 1 means saturate.
REQ-007 SHALL have the following ports:
- clk  in  1  sole clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- r_enable  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = sum a*b; 1 = sum (a-b)^2; latched at start.
- init_i  in  AW  first element index (inclusive).
- init_n  in  AW  end index (exclusive); init_n <= init_i means empty.
- init_acc  in  ACCW  signed initial accumulator.
- controlArr  in  1  host array access request.
- controlArrWEnable_a/_b  in  1  host write enable per array.
- controlArrAddr_a/_b  in  AW  host element address.
- controlArrWData_a/_b  in  DW  host write data.
- controlArrRData_a/_b  out  DW  host read data, one cycle after the address.
- busy  out  1  engine running.
- w_enable  out  1  one-cycle result strobe.
- result  out  ACCW  signed final accumulator.
- ovf  out  1  sticky overflow flag for the current run.

Function
REQ-008 Each array SHALL be stored as LANES banks; element e SHALL reside in bank e mod LANES, row e / LANES.
REQ-009 Bank reads SHALL have 1-cycle latency (registered address, combinational data).
REQ-010 Host access SHALL be granted only when busy=0 and controlArr=1.
REQ-011 While busy=1, host writes SHALL be dropped and controlArrRData SHALL read 0.
REQ-012 States SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE -> RUN on r_enable=1 with controlArr=0.
- RUN -> DRAIN after the last beat is issued.
- DRAIN -> DONE after 2 cycles.
- DONE -> IDLE after 1 cycle.
REQ-013 An empty range SHALL go from IDLE directly to DONE.
REQ-014 r_enable SHALL be ignored outside IDLE, and ignored in IDLE while controlArr=1.
REQ-015 At start, the engine SHALL latch mode, init_i and init_n, load the accumulator with init_acc, clear ovf and set busy.
REQ-016 Beat k SHALL cover elements init_i+k*LANES+j for j = 0..LANES-1.
REQ-017 Lane j SHALL address bank (e mod LANES) through a rotator, so each bank receives exactly one read per beat, including at unaligned starts.
REQ-018 Lanes with e >= init_n SHALL contribute 0.
REQ-019 Pipeline stages, one beat issued per RUN cycle:
- address issue;
- bank data;
- registered per-lane product (mode 0: a*b at 2*DW bits; mode 1: (a-b) at DW+1 bits, then squared);
- lane-sum added to the accumulator, all sign-extended to ACCW.
REQ-020 With cycle 0 defined as the cycle in which r_enable is sampled and N = init_n - init_i > 0, B = ceil(N/LANES), and w_enable SHALL be 1 in cycle B+4 only.
REQ-021 For an empty range, w_enable SHALL be 1 in cycle 2 with result = init_acc.
REQ-022 result SHALL update in the same cycle that w_enable=1 and SHALL hold until the next strobe or reset.
REQ-023 busy SHALL be 1 from cycle 1 through the w_enable cycle inclusive.
REQ-024 When SAT=0, accumulation SHALL wrap modulo 2^ACCW, and ovf SHALL set on signed overflow.
REQ-025 When SAT=1, accumulation SHALL clamp to +/-(2^(ACCW-1)) bounds, ovf SHALL set, and the accumulator SHALL stay clamped unless later terms move it back in range.
REQ-026 An index reaching DEPTH SHALL not be issued; it SHALL be treated as e >= init_n.

Reset
REQ-027 On rst=1 the block SHALL set state IDLE, busy=0, w_enable=0, result=0, ovf=0 and clear all pipeline valids.
REQ-028 rst SHALL take priority over every other input.
REQ-029 A reset mid-run SHALL abort the run with no w_enable strobe.
REQ-030 Bank memory contents SHALL NOT be reset.

Verification
REQ-031 Bench with LANES=4, DW=27, ACCW=64 SHALL cover:
- a[k]=k, b[k]=1, range [0,10), acc=5, mode 0 -> result 50, w_enable only in cycle 7.
- Unaligned: a[k]=k, b[k]=2, range [3,8), acc=0 -> result 50, w_enable in cycle 6, each bank read once per beat.
- mode 1: a=[10,3], b=[4,7], range [0,2), acc=0 -> result 52; negative case a=-5, b=3 -> 64.
- Empty range [5,5), acc=-7 -> result -7 in cycle 2; r_enable pulsed during busy ignored.
- SAT=1: acc=2^63-11, a=b=4, range [0,4) -> result 2^63-1, ovf=1; SAT=0 same stimulus -> wrapped negative, ovf=1.
- rst in cycle 3 of a 40-element run -> no strobe, result 0; host write during busy dropped, readback returns the old value after idle.
